udm_bus_initiator: RTL and testbench
====================================

// Module: udm_bus_initiator
// PURPOSE
//  Single-outstanding bus initiator for the req/ack/resp bus used by the UDM-attached CSR and
//  test-memory responders. It accepts one command at a time on a valid/ready port, drives one
//  bus transaction, collects the read response and returns a completion with an error flag.
//  A timeout error is returned if the responder never acks or never responds.
//  It sits between a host-side command source (debug FSM, test sequencer) and a bus responder.
// PARAMETERS
//  ADDR_W       32                 address width
//  DATA_W       32                 data width; byte enables are DATA_W/8 bits wide
//  BUS_TIMEOUT  1024*1024*100      cycles allowed from first req cycle to ack (write) or resp (read); >=2
// PORTS
//  clk_i          in   1         clock, all logic on rising edge
//  rst_i          in   1         reset, asynchronous, active-high
//  cmd_valid_i    in   1         command valid
//  cmd_ready_o    out  1         command ready (high only in IDLE)
//  cmd_we_i       in   1         1 = write, 0 = read
//  cmd_addr_bi    in   ADDR_W    byte address, passed through unmodified
//  cmd_be_bi      in   DATA_W/8  byte enables
//  cmd_wdata_bi   in   DATA_W    write data
//  rsp_valid_o    out  1         completion valid, held until rsp_ready_i
//  rsp_ready_i    in   1         completion accepted
//  rsp_err_o      out  1         1 = timeout
//  rsp_rdata_bo   out  DATA_W    read data; 0 for writes and errors
//  bus_req_o      out  1         bus request
//  bus_we_o       out  1         bus write enable
//  bus_addr_bo    out  ADDR_W    bus address
//  bus_be_bo      out  DATA_W/8  bus byte enables
//  bus_wdata_bo   out  DATA_W    bus write data
//  bus_ack_i      in   1         request accepted this cycle (sampled only while bus_req_o=1)
//  bus_resp_i     in   1         read data valid
//  bus_rdata_bi   in   DATA_W    read data
//  stray_resp_o   out  1         sticky: bus_resp_i seen outside WAIT_RESP; cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 except cmd_ready_o=1. Timeout counter=0.
//    Reset mid-transaction drops bus_req_o and rsp_valid_o immediately; any pending completion is lost.
//  - States: IDLE -> REQ -> (write) RSP | (read) WAIT_RESP -> RSP -> IDLE.
//  - IDLE: cmd_ready_o=1. Command is accepted when cmd_valid_i=1 in IDLE.
//    The command is registered; the next cycle the block is in REQ with bus_req_o=1.
//  - REQ: bus_req_o, we, addr, be, wdata are registered and held stable until the ack cycle.
//    bus_ack_i=1 completes the request phase; bus_req_o=0 in the following cycle.
//    Write + ack: go to RSP, err=0, rdata=0. Read + ack: go to WAIT_RESP.
//  - WAIT_RESP: bus_req_o=0. bus_resp_i is sampled from the cycle after ack.
//    A resp coincident with the ack cycle is not a completion: it sets stray_resp_o.
//    bus_resp_i=1 captures bus_rdata_bi; go to RSP with err=0.
//  - RSP: rsp_valid_o=1 with err/rdata stable. rsp_ready_i=1 -> IDLE next cycle.
//    There is no IDLE bypass: cmd_ready_o=0 while in RSP.
//  - Latency: accept cycle A; req high A+1..ack. Write ack at cycle K -> rsp_valid at K+1.
//    Read resp at cycle J -> rsp_valid at J+1.
//  - Timeout counter: cleared on command accept, increments once per cycle in REQ/WAIT_RESP,
//    and saturates. When it reaches BUS_TIMEOUT-1 without completion that cycle, the next state
//    is RSP with err=1, rdata=0, and bus_req_o drops. Completion (ack or resp) in the expiry cycle
//    wins over timeout. A late ack/resp after timeout is ignored, except that resp sets stray_resp_o.
//  - stray_resp_o: set by bus_resp_i=1 in IDLE, REQ or RSP.
//  - Width: counter is $clog2(BUS_TIMEOUT+1) bits. No address arithmetic; misaligned addresses
//    are passed through unchanged.
// TESTING
//  1. Write 0x00000000 <= 0x0000A5A5, be=4'hF, ack on the first req cycle
//     -> req high exactly 1 cycle; rsp_valid 1 cycle later, err=0, rdata=0.
//  2. Read 0x80000010, ack immediate, resp 2 cycles after ack with 0x12345678
//     -> rsp_valid 1 cycle after resp, rdata=0x12345678, err=0.
//  3. BUS_TIMEOUT=100, read with ack never given -> bus_req_o high 100 cycles, then rsp_valid, err=1,
//     rdata=0. Repeat with ack given but no resp -> err=1 at cycle 100 counted from first req cycle.
//  4. Resp in the exact expiry cycle -> err=0 and data captured. A later stray resp -> stray_resp_o=1.
//  5. rsp_ready_i held low 10 cycles with cmd_valid_i=1 -> rsp fields stable, cmd_ready_o=0,
//     no new bus_req_o until 1 cycle after rsp_ready_i.
//  6. Assert rst_i while in WAIT_RESP -> bus_req_o=0, rsp_valid_o=0, cmd_ready_o=1 asynchronously;
//     the next command runs normally.

Source files
------------

// File: rtl/udm_bus_initiator_if.sv
// Command, completion and responder-bus signals of udm_bus_initiator.
// The master modport is the initiator's view; slave is the host/responder side.
interface udm_bus_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [ADDR_W-1:0]   cmd_addr_bi;
  logic [DATA_W/8-1:0] cmd_be_bi;
  logic [DATA_W-1:0]   cmd_wdata_bi;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic                rsp_err_o;
  logic [DATA_W-1:0]   rsp_rdata_bo;
  logic                bus_req_o;
  logic                bus_we_o;
  logic [ADDR_W-1:0]   bus_addr_bo;
  logic [DATA_W/8-1:0] bus_be_bo;
  logic [DATA_W-1:0]   bus_wdata_bo;
  logic                bus_ack_i;
  logic                bus_resp_i;
  logic [DATA_W-1:0]   bus_rdata_bi;
  logic                stray_resp_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_bi, cmd_be_bi, cmd_wdata_bi,
    input  rsp_ready_i, bus_ack_i, bus_resp_i, bus_rdata_bi,
    output cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_bo,
    output bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo, stray_resp_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_bi, cmd_be_bi, cmd_wdata_bi,
    output rsp_ready_i, bus_ack_i, bus_resp_i, bus_rdata_bi,
    input  cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_bo,
    input  bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo, stray_resp_o
  );
endinterface

// File: rtl/udm_bus_initiator.sv
// Single-outstanding req/ack/resp bus initiator with a shared request/response timeout.
// All outputs are registered; the next-state logic feeds one always_ff.
module udm_bus_initiator #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BUS_TIMEOUT = 1024*1024*100
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  udm_bus_initiator_if.master  bus
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    RSP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                stray_q, stray_d;
  logic                expired;

  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    // A response is only legitimate once the request phase has been acked.
    stray_d     = stray_q | (bus.bus_resp_i && (state_q != WAIT_RESP));

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          state_d = REQ;
          ready_d = 1'b0;
          req_d   = 1'b1;
          we_d    = bus.cmd_we_i;
          addr_d  = bus.cmd_addr_bi;
          be_d    = bus.cmd_be_bi;
          wdata_d = bus.cmd_wdata_bi;
          cnt_d   = '0;
        end
      end

      REQ: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // Completion in the expiry cycle takes priority over the timeout.
        if (bus.bus_ack_i) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT_RESP;
          end
        end else if (expired) begin
          req_d       = 1'b0;
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end

      WAIT_RESP: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (bus.bus_resp_i) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus.bus_rdata_bi;
        end else if (expired) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end

      RSP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      stray_q     <= stray_d;
    end
  end

  assign bus.cmd_ready_o  = ready_q;
  assign bus.bus_req_o    = req_q;
  assign bus.bus_we_o     = we_q;
  assign bus.bus_addr_bo  = addr_q;
  assign bus.bus_be_bo    = be_q;
  assign bus.bus_wdata_bo = wdata_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.rsp_rdata_bo = rsp_rdata_q;
  assign bus.stray_resp_o = stray_q;

endmodule

// File: tb/tb_udm_bus_initiator.sv
// Directed bench for udm_bus_initiator: a per-cycle vector table for plain transfers,
// then hand-written sequences for timeout, expiry-cycle completion, backpressure and reset.
module tb_udm_bus_initiator;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BUS_TIMEOUT = 100;
  localparam int NVEC        = 13;

  typedef struct {
    logic        cmdValid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rspReady;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    logic        expReady;
    logic        expReq;
    logic        expValid;
    logic        expErr;
    logic [31:0] expRdata;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;
  vec_t vecs[NVEC];

  udm_bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

  udm_bus_initiator #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (busIf.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    busIf.cmd_valid_i  = 1'b0;
    busIf.cmd_we_i     = 1'b0;
    busIf.cmd_addr_bi  = '0;
    busIf.cmd_be_bi    = '0;
    busIf.cmd_wdata_bi = '0;
    busIf.rsp_ready_i  = 1'b0;
    busIf.bus_ack_i    = 1'b0;
    busIf.bus_resp_i   = 1'b0;
    busIf.bus_rdata_bi = '0;
  endtask

  task automatic issueCmd(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    busIf.cmd_valid_i  = 1'b1;
    busIf.cmd_we_i     = we;
    busIf.cmd_addr_bi  = addr;
    busIf.cmd_be_bi    = be;
    busIf.cmd_wdata_bi = wdata;
    step();
    busIf.cmd_valid_i  = 1'b0;
  endtask

  task automatic releaseRsp();
    busIf.rsp_ready_i = 1'b1;
    step();
    busIf.rsp_ready_i = 1'b0;
  endtask

  function automatic vec_t mkVec(
    input logic cv, input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
    input logic rr, input logic ack, input logic resp, input logic [31:0] rdata,
    input logic eReady, input logic eReq, input logic eValid, input logic eErr,
    input logic [31:0] eRdata, input logic [31:0] eAddr, input logic [31:0] eWdata);
    vec_t v;
    v.cmdValid = cv;     v.we = we;       v.addr = addr;     v.be = be;      v.wdata = wdata;
    v.rspReady = rr;     v.ack = ack;     v.resp = resp;     v.rdata = rdata;
    v.expReady = eReady; v.expReq = eReq; v.expValid = eValid; v.expErr = eErr;
    v.expRdata = eRdata; v.expAddr = eAddr; v.expWdata = eWdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    busIf.cmd_valid_i  = v.cmdValid;
    busIf.cmd_we_i     = v.we;
    busIf.cmd_addr_bi  = v.addr;
    busIf.cmd_be_bi    = v.be;
    busIf.cmd_wdata_bi = v.wdata;
    busIf.rsp_ready_i  = v.rspReady;
    busIf.bus_ack_i    = v.ack;
    busIf.bus_resp_i   = v.resp;
    busIf.bus_rdata_bi = v.rdata;
    step();
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d cmd_ready", i), 32'(busIf.cmd_ready_o), 32'(v.expReady));
    checkOutput($sformatf("v%0d bus_req", i), 32'(busIf.bus_req_o), 32'(v.expReq));
    checkOutput($sformatf("v%0d rsp_valid", i), 32'(busIf.rsp_valid_o), 32'(v.expValid));
    checkOutput($sformatf("v%0d rsp_err", i), 32'(busIf.rsp_err_o), 32'(v.expErr));
    checkOutput($sformatf("v%0d rsp_rdata", i), busIf.rsp_rdata_bo, v.expRdata);
    checkOutput($sformatf("v%0d stray", i), 32'(busIf.stray_resp_o), 32'd0);
    if (v.expReq) begin
      checkOutput($sformatf("v%0d bus_addr", i), busIf.bus_addr_bo, v.expAddr);
      checkOutput($sformatf("v%0d bus_wdata", i), busIf.bus_wdata_bo, v.expWdata);
    end
  endtask

  initial begin
    // Write with immediate ack, read with resp two cycles after ack, misaligned write with late ack.
    vecs[0]  = mkVec(1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_A5A5);
    vecs[1]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[3]  = mkVec(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0010, 32'h0);
    vecs[4]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[5]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[6]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'h0);
    vecs[7]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'h0);
    vecs[8]  = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mkVec(1'b1, 1'b1, 32'h0000_0003, 4'h6, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0003, 32'hDEAD_BEEF);
    vecs[10] = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0003, 32'hDEAD_BEEF);
    vecs[11] = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[12] = mkVec(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    idleInputs();
    rst = 1'b1;
    #12;
    checkOutput("reset cmd_ready", 32'(busIf.cmd_ready_o), 32'd1);
    checkOutput("reset bus_req", 32'(busIf.bus_req_o), 32'd0);
    checkOutput("reset rsp_valid", 32'(busIf.rsp_valid_o), 32'd0);
    checkOutput("reset rsp_err", 32'(busIf.rsp_err_o), 32'd0);
    checkOutput("reset rsp_rdata", busIf.rsp_rdata_bo, 32'd0);
    checkOutput("reset stray", 32'(busIf.stray_resp_o), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end
    idleInputs();

    // Read that is never acked: request held for exactly BUS_TIMEOUT cycles.
    issueCmd(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    n = 0;
    while (busIf.bus_req_o === 1'b1 && n < 300) begin
      n++;
      step();
    end
    checkOutput("noack req cycles", 32'(n), 32'd100);
    checkOutput("noack rsp_valid", 32'(busIf.rsp_valid_o), 32'd1);
    checkOutput("noack rsp_err", 32'(busIf.rsp_err_o), 32'd1);
    checkOutput("noack rsp_rdata", busIf.rsp_rdata_bo, 32'd0);
    releaseRsp();

    // Acked read that never responds: error 100 cycles after the first req cycle.
    issueCmd(1'b0, 32'h0000_0044, 4'hF, 32'h0);
    busIf.bus_ack_i = 1'b1;
    n = 0;
    while (busIf.rsp_valid_o !== 1'b1 && n < 300) begin
      step();
      busIf.bus_ack_i = 1'b0;
      n++;
    end
    checkOutput("noresp cycles", 32'(n), 32'd100);
    checkOutput("noresp rsp_err", 32'(busIf.rsp_err_o), 32'd1);
    checkOutput("noresp rsp_rdata", busIf.rsp_rdata_bo, 32'd0);
    releaseRsp();

    // Response landing in the expiry cycle still completes normally.
    issueCmd(1'b0, 32'h0000_0048, 4'hF, 32'h0);
    busIf.bus_ack_i = 1'b1;
    step();
    busIf.bus_ack_i = 1'b0;
    repeat (98) step();
    checkOutput("expiry pre rsp_valid", 32'(busIf.rsp_valid_o), 32'd0);
    busIf.bus_resp_i   = 1'b1;
    busIf.bus_rdata_bi = 32'hCAFE_F00D;
    step();
    busIf.bus_resp_i   = 1'b0;
    checkOutput("expiry rsp_valid", 32'(busIf.rsp_valid_o), 32'd1);
    checkOutput("expiry rsp_err", 32'(busIf.rsp_err_o), 32'd0);
    checkOutput("expiry rsp_rdata", busIf.rsp_rdata_bo, 32'hCAFE_F00D);
    checkOutput("expiry stray", 32'(busIf.stray_resp_o), 32'd0);
    busIf.bus_resp_i = 1'b1;
    step();
    busIf.bus_resp_i = 1'b0;
    checkOutput("late resp stray", 32'(busIf.stray_resp_o), 32'd1);
    checkOutput("late resp rdata", busIf.rsp_rdata_bo, 32'hCAFE_F00D);
    releaseRsp();
    checkOutput("stray sticky idle", 32'(busIf.stray_resp_o), 32'd1);

    // Completion held under backpressure while a new command waits.
    issueCmd(1'b0, 32'h0000_0050, 4'hF, 32'h0);
    busIf.bus_ack_i = 1'b1;
    step();
    busIf.bus_ack_i    = 1'b0;
    busIf.bus_resp_i   = 1'b1;
    busIf.bus_rdata_bi = 32'h55AA_1234;
    step();
    busIf.bus_resp_i   = 1'b0;
    busIf.bus_rdata_bi = 32'h0;
    busIf.cmd_valid_i  = 1'b1;
    busIf.cmd_we_i     = 1'b1;
    busIf.cmd_addr_bi  = 32'h0000_0060;
    busIf.cmd_be_bi    = 4'hF;
    busIf.cmd_wdata_bi = 32'h0000_0777;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp%0d rsp_valid", i), 32'(busIf.rsp_valid_o), 32'd1);
      checkOutput($sformatf("bp%0d rsp_rdata", i), busIf.rsp_rdata_bo, 32'h55AA_1234);
      checkOutput($sformatf("bp%0d cmd_ready", i), 32'(busIf.cmd_ready_o), 32'd0);
      checkOutput($sformatf("bp%0d bus_req", i), 32'(busIf.bus_req_o), 32'd0);
      step();
    end
    busIf.rsp_ready_i = 1'b1;
    step();
    busIf.rsp_ready_i = 1'b0;
    checkOutput("bp release rsp_valid", 32'(busIf.rsp_valid_o), 32'd0);
    checkOutput("bp release cmd_ready", 32'(busIf.cmd_ready_o), 32'd1);
    checkOutput("bp release bus_req", 32'(busIf.bus_req_o), 32'd0);
    step();
    busIf.cmd_valid_i = 1'b0;
    checkOutput("bp next bus_req", 32'(busIf.bus_req_o), 32'd1);
    checkOutput("bp next bus_addr", busIf.bus_addr_bo, 32'h0000_0060);
    busIf.bus_ack_i = 1'b1;
    step();
    busIf.bus_ack_i = 1'b0;
    checkOutput("bp next rsp_valid", 32'(busIf.rsp_valid_o), 32'd1);
    releaseRsp();

    // Asynchronous reset while waiting for a read response.
    issueCmd(1'b0, 32'h0000_0070, 4'hF, 32'h0);
    busIf.bus_ack_i = 1'b1;
    step();
    busIf.bus_ack_i = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst bus_req", 32'(busIf.bus_req_o), 32'd0);
    checkOutput("async rst rsp_valid", 32'(busIf.rsp_valid_o), 32'd0);
    checkOutput("async rst cmd_ready", 32'(busIf.cmd_ready_o), 32'd1);
    checkOutput("async rst stray", 32'(busIf.stray_resp_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Resp coincident with ack is stray; the real resp afterwards completes the read.
    issueCmd(1'b0, 32'h0000_0080, 4'hF, 32'h0);
    busIf.bus_ack_i    = 1'b1;
    busIf.bus_resp_i   = 1'b1;
    busIf.bus_rdata_bi = 32'h0000_0BAD;
    step();
    busIf.bus_ack_i  = 1'b0;
    busIf.bus_resp_i = 1'b0;
    checkOutput("coincident stray", 32'(busIf.stray_resp_o), 32'd1);
    checkOutput("coincident rsp_valid", 32'(busIf.rsp_valid_o), 32'd0);
    step();
    busIf.bus_resp_i   = 1'b1;
    busIf.bus_rdata_bi = 32'h0000_600D;
    step();
    busIf.bus_resp_i   = 1'b0;
    checkOutput("post rst rsp_valid", 32'(busIf.rsp_valid_o), 32'd1);
    checkOutput("post rst rsp_rdata", busIf.rsp_rdata_bo, 32'h0000_600D);
    checkOutput("post rst rsp_err", 32'(busIf.rsp_err_o), 32'd0);
    releaseRsp();
    checkOutput("post rst cmd_ready", 32'(busIf.cmd_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
